add_nibble_sched: RTL

- Shares one 4-bit carry look-ahead adder slice (ADD_FAST) between two requesters.
- Performs multi-precision additions of 4*NIBBLES-bit operands, nibble-serially, LSB nibble first.
- Carry is held in a register between nibbles.
- Round-robin arbitration and a REQ/DONE handshake per requester; sits between the operand producers and the shared arithmetic slice.

---
 rtl/add_nibble_sched.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/add_nibble_sched.sv
// Two-requester scheduler that time-shares one 4-bit carry look-ahead slice for
// nibble-serial multi-precision addition, with round-robin grant and REQ/DONE handshake.

module add_fast (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        s    = p ^ c[3:0];
        co   = c[4];
    end
endmodule

module add_nibble_sched #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   REQ0,
    input  logic [4*NIBBLES-1:0]   A0,
    input  logic [4*NIBBLES-1:0]   B0,
    input  logic                   CI0,
    input  logic                   REQ1,
    input  logic [4*NIBBLES-1:0]   A1,
    input  logic [4*NIBBLES-1:0]   B1,
    input  logic                   CI1,
    output logic [4*NIBBLES-1:0]   S,
    output logic                   CO,
    output logic                   DONE0,
    output logic                   DONE1,
    output logic                   BUSY,
    output logic                   OWNER
);
    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  a_sh_q, a_sh_d;
    logic [W-1:0]  b_sh_q, b_sh_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          owner_q, owner_d;
    logic [W-1:0]  s_q, s_d;
    logic          co_q, co_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;
    logic          busy_q, busy_d;

    logic          grant;
    logic [3:0]    slice_s;
    logic          slice_co;

    // Operands shift right each RUN cycle so the slice always sees the low nibble.
    add_fast u_slice (
        .a  (a_sh_q[3:0]),
        .b  (b_sh_q[3:0]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        owner_d = owner_q;
        s_d     = s_q;
        co_d    = co_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        busy_d  = busy_q;
        grant   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (REQ0 || REQ1) begin
                    grant   = (REQ0 && REQ1) ? ~last_q : REQ1;
                    last_d  = grant;
                    owner_d = grant;
                    a_sh_d  = grant ? A1 : A0;
                    b_sh_d  = grant ? B1 : B0;
                    carry_d = grant ? CI1 : CI0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                s_d[{cnt_q, 2'b00} +: 4] = slice_s;
                carry_d = slice_co;
                cnt_d   = cnt_q + 1'b1;
                a_sh_d  = a_sh_q >> 4;
                b_sh_d  = b_sh_q >> 4;
                if (cnt_q == LAST_CNT) begin
                    co_d    = slice_co;
                    state_d = ST_DONE;
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            s_q     <= s_d;
            co_q    <= co_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            busy_q  <= busy_d;
        end
    end

    assign S     = s_q;
    assign CO    = co_q;
    assign DONE0 = done0_q;
    assign DONE1 = done1_q;
    assign BUSY  = busy_q;
    assign OWNER = owner_q;
endmodule
